// File: rtl/rf_writeback_queue.sv
// Program-ordered writeback queue feeding the two write ports of the integer register file.
// Filters x0 and same-destination pair writes on entry, drains one pair per cycle, and reports pending writes.
module rf_writeback_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_v0,
   input  logic [4:0]             in_rd0,
   input  logic [XLEN-1:0]        in_data0,
   input  logic                   in_v1,
   input  logic [4:0]             in_rd1,
   input  logic [XLEN-1:0]        in_data1,
   input  logic                   rf_hold,
   output logic                   Wen1,
   output logic [4:0]             Rd_addr1,
   output logic [XLEN-1:0]        write_data1,
   output logic                   Wen2,
   output logic [4:0]             Rd_addr2,
   output logic [XLEN-1:0]        write_data2,
   input  logic [4:0]             q_addr_a,
   input  logic [4:0]             q_addr_b,
   output logic                   q_pend_a,
   output logic                   q_pend_b,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic            v0;
      logic [4:0]      rd0;
      logic [XLEN-1:0] data0;
      logic            v1;
      logic [4:0]      rd1;
      logic [XLEN-1:0] data1;
   } entry_t;

   entry_t          mem_q [DEPTH];
   entry_t          push_entry;
   entry_t          head;

   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;

   logic            wen1_q, wen1_d;
   logic            wen2_q, wen2_d;
   logic [4:0]      rd_addr1_q, rd_addr1_d;
   logic [4:0]      rd_addr2_q, rd_addr2_d;
   logic [XLEN-1:0] wdata1_q, wdata1_d;
   logic [XLEN-1:0] wdata2_q, wdata2_d;

   logic            push;
   logic            pop;
   logic            v1_filt;
   logic [PW-1:0]   offs;
   logic            occ;

   assign in_ready = (count_q != CW'(DEPTH));
   assign push     = in_valid && in_ready;
   assign pop      = (count_q != '0) && !rf_hold;
   assign head     = mem_q[rd_ptr_q];

   // x0 is never written; on a same-destination pair the younger lane1 result wins.
   always_comb begin
      v1_filt          = in_v1 && (in_rd1 != 5'd0);
      push_entry.v1    = v1_filt;
      push_entry.rd1   = in_rd1;
      push_entry.data1 = in_data1;
      push_entry.v0    = in_v0 && (in_rd0 != 5'd0) && !(v1_filt && (in_rd1 == in_rd0));
      push_entry.rd0   = in_rd0;
      push_entry.data0 = in_data0;
   end

   always_comb begin
      wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d    = count_q;
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);

      wen1_d     = 1'b0;
      wen2_d     = 1'b0;
      rd_addr1_d = rd_addr1_q;
      rd_addr2_d = rd_addr2_q;
      wdata1_d   = wdata1_q;
      wdata2_d   = wdata2_q;
      if (pop) begin
         wen1_d     = head.v0;
         rd_addr1_d = head.rd0;
         wdata1_d   = head.data0;
         wen2_d     = head.v1;
         rd_addr2_d = head.rd1;
         wdata2_d   = head.data1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         wen1_q     <= 1'b0;
         wen2_q     <= 1'b0;
         rd_addr1_q <= '0;
         rd_addr2_q <= '0;
         wdata1_q   <= '0;
         wdata2_q   <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         wen1_q     <= wen1_d;
         wen2_q     <= wen2_d;
         rd_addr1_q <= rd_addr1_d;
         rd_addr2_q <= rd_addr2_d;
         wdata1_q   <= wdata1_d;
         wdata2_q   <= wdata2_d;
      end
   end

   // NOTE: storage is deliberately not reset; count_q/rd_ptr_q decide which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_entry;
   end

   // An entry is live when its distance from the read pointer is below the occupancy.
   always_comb begin
      q_pend_a = 1'b0;
      q_pend_b = 1'b0;
      offs     = '0;
      occ      = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         offs = PW'(i) - rd_ptr_q;
         occ  = ({1'b0, offs} < count_q);
         if (occ && mem_q[i].v0 && (mem_q[i].rd0 == q_addr_a)) q_pend_a = 1'b1;
         if (occ && mem_q[i].v1 && (mem_q[i].rd1 == q_addr_a)) q_pend_a = 1'b1;
         if (occ && mem_q[i].v0 && (mem_q[i].rd0 == q_addr_b)) q_pend_b = 1'b1;
         if (occ && mem_q[i].v1 && (mem_q[i].rd1 == q_addr_b)) q_pend_b = 1'b1;
      end
      if (wen1_q && (rd_addr1_q == q_addr_a)) q_pend_a = 1'b1;
      if (wen2_q && (rd_addr2_q == q_addr_a)) q_pend_a = 1'b1;
      if (wen1_q && (rd_addr1_q == q_addr_b)) q_pend_b = 1'b1;
      if (wen2_q && (rd_addr2_q == q_addr_b)) q_pend_b = 1'b1;
      if (q_addr_a == 5'd0) q_pend_a = 1'b0;
      if (q_addr_b == 5'd0) q_pend_b = 1'b0;
   end

   assign Wen1        = wen1_q;
   assign Rd_addr1    = rd_addr1_q;
   assign write_data1 = wdata1_q;
   assign Wen2        = wen2_q;
   assign Rd_addr2    = rd_addr2_q;
   assign write_data2 = wdata2_q;
   assign count       = count_q;

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed bench for rf_writeback_queue: a vector table for the single-pair cases,
// then hand sequences for hold/full, pointer wrap, pending tracking and mid-drain reset.
module tb_rf_writeback_queue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_v0, in_v1;
   logic [4:0]  in_rd0, in_rd1;
   logic [63:0] in_data0, in_data1;
   logic        rf_hold;
   logic        Wen1, Wen2;
   logic [4:0]  Rd_addr1, Rd_addr2;
   logic [63:0] write_data1, write_data2;
   logic [4:0]  q_addr_a, q_addr_b;
   logic        q_pend_a, q_pend_b;
   logic [2:0]  count;

   int checks   = 0;
   int failures = 0;

   rf_writeback_queue #(.DEPTH(4), .XLEN(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_v0(in_v0), .in_rd0(in_rd0), .in_data0(in_data0),
      .in_v1(in_v1), .in_rd1(in_rd1), .in_data1(in_data1),
      .rf_hold(rf_hold),
      .Wen1(Wen1), .Rd_addr1(Rd_addr1), .write_data1(write_data1),
      .Wen2(Wen2), .Rd_addr2(Rd_addr2), .write_data2(write_data2),
      .q_addr_a(q_addr_a), .q_addr_b(q_addr_b),
      .q_pend_a(q_pend_a), .q_pend_b(q_pend_b),
      .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        vld;
      logic        v0;
      logic [4:0]  rd0;
      logic [63:0] d0;
      logic        v1;
      logic [4:0]  rd1;
      logic [63:0] d1;
      logic [4:0]  qa;
      logic        e_wen1;
      logic [4:0]  e_rd1;
      logic [63:0] e_wd1;
      logic        e_wen2;
      logic [4:0]  e_rd2;
      logic [63:0] e_wd2;
      logic [2:0]  e_cnt;
      logic        e_pa;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic vld, input logic v0, input logic [4:0] rd0, input logic [63:0] d0,
                        input logic v1, input logic [4:0] rd1, input logic [63:0] d1);
      in_valid = vld;
      in_v0    = v0;
      in_rd0   = rd0;
      in_data0 = d0;
      in_v1    = v1;
      in_rd1   = rd1;
      in_data1 = d1;
   endtask

   task automatic check_out(input string tag, input logic w1, input logic [4:0] a1, input logic [63:0] d1,
                            input logic w2, input logic [4:0] a2, input logic [63:0] d2);
      check({tag, " wen1"},  64'(Wen1), 64'(w1));
      check({tag, " addr1"}, 64'(Rd_addr1), 64'(a1));
      check({tag, " data1"}, write_data1, d1);
      check({tag, " wen2"},  64'(Wen2), 64'(w2));
      check({tag, " addr2"}, 64'(Rd_addr2), 64'(a2));
      check({tag, " data2"}, write_data2, d2);
   endtask

   initial begin
      // vld v0 rd0 d0 v1 rd1 d1 qa | wen1 rd1 wd1 wen2 rd2 wd2 cnt pend_a
      vecs[0]  = '{1'b1, 1'b1, 5'd5, 64'h11, 1'b1, 5'd6, 64'h22, 5'd5,  1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,  3'd1, 1'b1};
      vecs[1]  = '{1'b0, 1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,  5'd5,  1'b1, 5'd5, 64'h11, 1'b1, 5'd6, 64'h22, 3'd0, 1'b1};
      vecs[2]  = '{1'b0, 1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,  5'd5,  1'b0, 5'd5, 64'h11, 1'b0, 5'd6, 64'h22, 3'd0, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 5'd9, 64'hA,  1'b1, 5'd9, 64'hB,  5'd9,  1'b0, 5'd5, 64'h11, 1'b0, 5'd6, 64'h22, 3'd1, 1'b1};
      vecs[4]  = '{1'b0, 1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,  5'd9,  1'b0, 5'd9, 64'hA,  1'b1, 5'd9, 64'hB,  3'd0, 1'b1};
      vecs[5]  = '{1'b1, 1'b1, 5'd0, 64'hFF, 1'b0, 5'd0, 64'h0,  5'd0,  1'b0, 5'd9, 64'hA,  1'b0, 5'd9, 64'hB,  3'd1, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,  5'd0,  1'b0, 5'd0, 64'hFF, 1'b0, 5'd0, 64'h0,  3'd0, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,  5'd0,  1'b0, 5'd0, 64'hFF, 1'b0, 5'd0, 64'h0,  3'd0, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 5'd7, 64'h33, 1'b0, 5'd7, 64'h44, 5'd7,  1'b0, 5'd0, 64'hFF, 1'b0, 5'd0, 64'h0,  3'd1, 1'b1};
      vecs[9]  = '{1'b0, 1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,  5'd7,  1'b1, 5'd7, 64'h33, 1'b0, 5'd7, 64'h44, 3'd0, 1'b1};
      vecs[10] = '{1'b0, 1'b0, 5'd0, 64'h0,  1'b0, 5'd0, 64'h0,  5'd7,  1'b0, 5'd7, 64'h33, 1'b0, 5'd7, 64'h44, 3'd0, 1'b0};

      rst_n    = 1'b0;
      rf_hold  = 1'b0;
      q_addr_a = 5'd0;
      q_addr_b = 5'd0;
      drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
      tick();
      tick();
      check("reset count", 64'(count), 64'd0);
      check("reset in_ready", 64'(in_ready), 64'd1);
      check_out("reset", 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].vld, vecs[i].v0, vecs[i].rd0, vecs[i].d0, vecs[i].v1, vecs[i].rd1, vecs[i].d1);
         q_addr_a = vecs[i].qa;
         tick();
         check_out($sformatf("vec%0d", i), vecs[i].e_wen1, vecs[i].e_rd1, vecs[i].e_wd1,
                   vecs[i].e_wen2, vecs[i].e_rd2, vecs[i].e_wd2);
         check($sformatf("vec%0d count", i), 64'(count), 64'(vecs[i].e_cnt));
         check($sformatf("vec%0d pend_a", i), 64'(q_pend_a), 64'(vecs[i].e_pa));
      end

      // Fill under hold, attempt a fifth push, then drain in order.
      rf_hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 5'(i + 1), 64'(256 + i), 1'b1, 5'(i + 17), 64'(512 + i));
         tick();
         check($sformatf("fill%0d count", i), 64'(count), 64'(i + 1));
         check($sformatf("fill%0d wen1", i), 64'(Wen1), 64'd0);
      end
      check("full in_ready", 64'(in_ready), 64'd0);
      drive(1'b1, 1'b1, 5'd31, 64'hDEAD, 1'b1, 5'd30, 64'hBEEF);
      tick();
      check("full 5th count", 64'(count), 64'd4);
      check("full held wen2", 64'(Wen2), 64'd0);
      drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
      rf_hold = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_out($sformatf("drain%0d", i), 1'b1, 5'(i + 1), 64'(256 + i), 1'b1, 5'(i + 17), 64'(512 + i));
         check($sformatf("drain%0d count", i), 64'(count), 64'(3 - i));
         if (i == 0) check("drain in_ready", 64'(in_ready), 64'd1);
      end
      tick();
      check("after drain wen1", 64'(Wen1), 64'd0);
      check("after drain wen2", 64'(Wen2), 64'd0);

      // Back-to-back burst with simultaneous push and pop across the pointer wrap.
      for (int j = 0; j < 6; j++) begin
         drive(1'b1, 1'b1, 5'(j + 2), 64'(768 + j), 1'b1, 5'(j + 20), 64'(1024 + j));
         tick();
         check($sformatf("burst%0d count", j), 64'(count), 64'd1);
         if (j > 0)
            check_out($sformatf("burst%0d", j), 1'b1, 5'(j + 1), 64'(767 + j), 1'b1, 5'(j + 19), 64'(1023 + j));
      end
      drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
      tick();
      check_out("burst tail", 1'b1, 5'd7, 64'(773), 1'b1, 5'd25, 64'(1029));
      check("burst tail count", 64'(count), 64'd0);
      tick();

      // Pending tracking through queue, output register and retirement.
      rf_hold  = 1'b1;
      q_addr_a = 5'd14;
      q_addr_b = 5'd13;
      drive(1'b1, 1'b1, 5'd14, 64'h55, 1'b0, 5'd13, 64'h66);
      tick();
      check("pend queued a", 64'(q_pend_a), 64'd1);
      check("pend invalid b", 64'(q_pend_b), 64'd0);
      drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
      tick();
      check("pend held a", 64'(q_pend_a), 64'd1);
      rf_hold = 1'b0;
      tick();
      check("pend outreg wen1", 64'(Wen1), 64'd1);
      check("pend outreg a", 64'(q_pend_a), 64'd1);
      check("pend outreg b", 64'(q_pend_b), 64'd0);
      tick();
      check("pend retired a", 64'(q_pend_a), 64'd0);

      // Reset while three entries are queued and draining is enabled.
      rf_hold  = 1'b1;
      q_addr_a = 5'd3;
      q_addr_b = 5'd4;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 5'(i + 3), 64'(i + 1), 1'b1, 5'(i + 10), 64'(i + 5));
         tick();
      end
      check("prereset count", 64'(count), 64'd3);
      check("prereset pend_b", 64'(q_pend_b), 64'd1);
      drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
      rf_hold = 1'b0;
      rst_n   = 1'b0;
      tick();
      check("midreset count", 64'(count), 64'd0);
      check("midreset wen1", 64'(Wen1), 64'd0);
      check("midreset wen2", 64'(Wen2), 64'd0);
      check("midreset pend_a", 64'(q_pend_a), 64'd0);
      check("midreset pend_b", 64'(q_pend_b), 64'd0);
      check("midreset in_ready", 64'(in_ready), 64'd1);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("postreset%0d wen", i), 64'(Wen1 | Wen2), 64'd0);
         check($sformatf("postreset%0d count", i), 64'(count), 64'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
